// File: rtl/decode_inst_queue.sv
// decode_inst_queue
//
// Instruction buffer between fetch and decode. Holds up to DEPTH fetched
// {pc, inst, predicted-taken} entries so a decode-side hazard stall keeps the
// oldest entry instead of dropping it. A branch-mispredict flush empties the
// queue. Occupancy and a stall-cycle counter are exported for the debug path.
//
// All state updates on the falling edge of clk, like the other pipeline
// registers. Reset is synchronous and active-high.
//
// Handshake (both sides): a transfer happens on an update edge where valid and
// ready are both 1. in_ready depends only on registered state (never on
// out_ready), and out_valid depends only on registered state (no same-cycle
// bypass from fetch to decode).
//
// Ports:
//   clk            clock (falling-edge updates)
//   rst            synchronous reset, active-high; beats flush, push and pop
//   flush          mispredict flush; empties the queue, beats push and pop
//   in_valid       fetch presents an entry
//   in_ready       queue can accept an entry (not full)
//   in_pc          fetched pc
//   in_inst        fetched instruction bits
//   in_pred_taken  branch predicted taken
//   out_valid      head entry valid for decode (not empty)
//   out_ready      decode consumes the head; low on a data hazard
//   out_pc         head pc (zero when empty)
//   out_inst       head instruction (zero when empty)
//   out_pred_taken head prediction (zero when empty)
//   occupancy      current entry count, 0..DEPTH
//   stall_cnt      saturating count of edges with out_valid=1, out_ready=0

module decode_inst_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [XLEN-1:0]              in_pc,
   input  logic [XLEN-1:0]              in_inst,
   input  logic                         in_pred_taken,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [XLEN-1:0]              out_pc,
   output logic [XLEN-1:0]              out_inst,
   output logic                         out_pred_taken,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;   // extra MSB is the wrap bit
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0] headPtr;
   logic [PTR_W-1:0] tailPtr;
   logic [PTR_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] stallCnt;

   logic [XLEN-1:0]  pcMem   [DEPTH];
   logic [XLEN-1:0]  instMem [DEPTH];
   logic             predMem [DEPTH];

   // Pointer difference modulo 2^PTR_W gives 0..DEPTH thanks to the wrap bit.
   assign count = tailPtr - headPtr;
   assign full  = (count == PTR_W'(DEPTH));
   assign empty = (count == '0);

   assign in_ready  = !full;
   assign out_valid = !empty;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   assign occupancy = OCC_W'(count);
   assign stall_cnt = stallCnt;

   // Head payload is gated to zero when empty so stale or never-written
   // storage never leaks onto the decode bus.
   always_comb begin
      out_pc         = '0;
      out_inst       = '0;
      out_pred_taken = 1'b0;
      if (!empty) begin
         out_pc         = pcMem[headPtr[IDX_W-1:0]];
         out_inst       = instMem[headPtr[IDX_W-1:0]];
         out_pred_taken = predMem[headPtr[IDX_W-1:0]];
      end
   end

   // Pointers and stall counter.
   always_ff @(negedge clk) begin
      if (rst) begin
         headPtr  <= '0;
         tailPtr  <= '0;
         stallCnt <= '0;
      end else begin
         if (flush) begin
            // Incoming entry and any same-edge pop are discarded.
            headPtr <= '0;
            tailPtr <= '0;
         end else begin
            if (push) tailPtr <= tailPtr + 1'b1;
            if (pop)  headPtr <= headPtr + 1'b1;
         end
         // A flush edge is not a hazard stall; the counter survives flushes.
         if (out_valid && !out_ready && !flush && (stallCnt != '1))
            stallCnt <= stallCnt + 1'b1;
      end
   end

   // Payload storage; not reset, only written on an accepted push.
   always_ff @(negedge clk) begin
      if (push && !rst && !flush) begin
         pcMem[tailPtr[IDX_W-1:0]]   <= in_pc;
         instMem[tailPtr[IDX_W-1:0]] <= in_inst;
         predMem[tailPtr[IDX_W-1:0]] <= in_pred_taken;
      end
   end

endmodule

// File: doc/decode_inst_queue.md
Name: decode_inst_queue

Overview:
- Parametrised instruction buffer between the fetch and decode stages. It replaces the single fetch→decode pipe register, which loses the held instruction when a hazard injects a bubble.
- Holds up to DEPTH fetched {pc, inst, predicted-taken} entries with a valid/ready handshake on both sides.
- Hazard stalls hold the oldest entry instead of dropping it; a branch-mispredict flush empties the queue.
- Provides occupancy and stall-cycle counters for the debug path.

Parameters:
- XLEN, 32, width of pc and inst.
- DEPTH, 4, number of entries; power of two, ≥2.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on falling edge, matching the other pipeline registers.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  branch-predict-miss flush.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept an entry.
- in_pc  in  XLEN  fetched pc.
- in_inst  in  XLEN  fetched instruction bits.
- in_pred_taken  in  1  branch predicted taken.
- out_valid  out  1  head entry valid for decode.
- out_ready  in  1  decode consumes the head; driven low on a data hazard.
- out_pc  out  XLEN  head pc.
- out_inst  out  XLEN  head instruction.
- out_pred_taken  out  1  head prediction.
- occupancy  out  $clog2(DEPTH+1)  current entry count.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: circular array of DEPTH entries. Head and tail pointers are $clog2(DEPTH)+1 bits; the extra bit is the wrap bit.
- count = tail − head (modulo). full = count==DEPTH. empty = count==0.
- in_ready = !full. Purely from registered state; no dependence on out_ready.
- push = in_valid & in_ready. Writes the entry at tail[ptr]; tail increments and wraps naturally at DEPTH.
- pop = out_valid & out_ready. head increments.
- out_valid = !empty.
- out_pc/out_inst/out_pred_taken: combinational read of the head entry when out_valid=1; all zeros when empty.
- Latency: an entry pushed into an empty queue appears at the output on the next update edge. No same-cycle bypass.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Full: in_ready=0, so a push is impossible even if a pop happens that cycle; in_ready rises the edge after the pop.
- Empty: out_valid=0, so out_ready is ignored and no pop occurs.
- flush=1: head=tail=0 next edge, occupancy=0, out_valid=0, in_ready=1. Flush has priority over a same-cycle push or pop; the incoming entry is discarded. Stored payloads need not be cleared.
- stall_cnt: increments on each edge where out_valid & !out_ready & !flush. Saturates at all-ones. Cleared only by rst; flush does not clear it.
- rst=1: same as flush, plus stall_cnt=0. Reset values: in_ready=1, out_valid=0, all out payloads 0, occupancy=0, stall_cnt=0.
- rst mid-operation discards all entries. rst has priority over flush, push and pop.
- occupancy always equals count; never exceeds DEPTH.

Test Plan:
- Reset, then push pc=0x100/inst=0x00500093/pred=0 into empty queue → out_valid=1 one edge later with the same fields; occupancy=1; pop with out_ready=1 → empty, outputs 0.
- out_ready=0, push 4 entries pc=0x0,0x4,0x8,0xC (DEPTH=4) → in_ready=0, occupancy=4; a fifth push is ignored; stall_cnt=4 (counting from first valid edge) after 4 stalled edges with out_valid=1; release → pops in order 0x0,0x4,0x8,0xC.
- Steady stream with in_valid=out_ready=1 over 10 edges → occupancy holds at 1, order preserved across pointer wrap (>DEPTH pushes), no lost entries.
- Queue holds 3 entries; flush with simultaneous in_valid, pc=0x200 → next edge occupancy=0, out_valid=0, 0x200 not stored; stall_cnt unchanged.
- Full queue with pop this edge and in_valid=1 → no push this edge (in_ready=0); occupancy=3, then push accepted next edge → 4.
- rst asserted with 2 entries and stall_cnt=7 → all outputs return to reset values on the next edge.
